mem_port_arbiter: RTL

- Shares the single 32-bit instruction/data memory port between the instruction fetch stage (IF) and the load/store unit (LS).
- Sequences one transaction at a time: grant, memory handshake, response return to the owning requester.
- Supports fetch flush, which kills an in-flight fetch on a branch or jump redirect.
- Provides a watchdog timeout that terminates a hung access with an error.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the arbiter, its two requesters and memory.
// master: arbiter view; slave: environment (IF, LS, memory) view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  if_req, if_addr, if_flush,
    input  ls_req, ls_we, ls_addr,
    input  ls_wdata, ls_be,
    input  mem_ack, mem_rdata,
    output if_ack, if_rdata,
    output ls_ack, ls_rdata, err,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be
  );

  modport slave (
    output if_req, if_addr, if_flush,
    output ls_req, ls_we, ls_addr,
    output ls_wdata, ls_be,
    output mem_ack, mem_rdata,
    input  if_ack, if_rdata,
    input  ls_ack, ls_rdata, err,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between fetch (IF) and load/store (LS).
// Ports: clk, rst (async, active-high), bus (requesters + memory).
// Fetch flush kills an in-flight fetch; a watchdog ends hung accesses
// with err. Build macro ARB_ROUND_ROBIN_EN alternates grants on ties;
// without it LS wins ties.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kill_q, kill_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          if_ack_q, if_ack_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          ls_ack_q, ls_ack_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;
  logic          err_q, err_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic          last_if_q, last_if_d;
`endif

  logic if_elig, ls_elig;
  logic grant_if, grant_ls;
  logic kill_eff, done, tmo;

  // A held req is not re-granted in the cycle its own ack is visible.
  assign if_elig = bus.if_req & ~if_ack_q & ~bus.if_flush;
  assign ls_elig = bus.ls_req & ~ls_ack_q;

  // Flush in the completion cycle itself must also kill the fetch.
  assign kill_eff = kill_q |
                    ((state_q == BUSY_IF) & bus.if_flush);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_ack_d    = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    err_d       = 1'b0;
    grant_if    = 1'b0;
    grant_ls    = 1'b0;
    done        = 1'b0;
    tmo         = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_if_d   = last_if_q;
`endif

    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (if_elig && ls_elig) begin
`ifdef ARB_ROUND_ROBIN_EN
          grant_if = ~last_if_q;
          grant_ls = last_if_q;
`else
          grant_ls = 1'b1;
`endif
        end else if (if_elig) begin
          grant_if = 1'b1;
        end else if (ls_elig) begin
          grant_ls = 1'b1;
        end

        if (grant_if) begin
          state_d     = BUSY_IF;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
        end else if (grant_ls) begin
          state_d     = BUSY_LS;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.ls_we;
          mem_addr_d  = bus.ls_addr;
          mem_wdata_d = bus.ls_wdata;
          mem_be_d    = bus.ls_be;
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (grant_if || grant_ls) begin
          last_if_d = grant_if;
        end
`endif
      end

      BUSY_IF, BUSY_LS: begin
        // A real ack wins over a coincident timeout.
        done = bus.mem_ack | (cnt_q == TMAX);
        tmo  = ~bus.mem_ack;
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          kill_d    = 1'b0;
          if (state_q == BUSY_IF) begin
            if (!kill_eff) begin
              if_ack_d   = 1'b1;
              err_d      = tmo;
              if_rdata_d = tmo ? 32'h0 : bus.mem_rdata;
            end
          end else begin
            ls_ack_d   = 1'b1;
            err_d      = tmo;
            ls_rdata_d = (tmo || mem_we_q) ? 32'h0
                                           : bus.mem_rdata;
          end
        end else begin
          cnt_d  = cnt_q + 1'b1;
          kill_d = kill_eff;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_ack_q    <= 1'b0;
      ls_rdata_q  <= '0;
      err_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_if_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      ls_ack_q    <= ls_ack_d;
      ls_rdata_q  <= ls_rdata_d;
      err_q       <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_if_q   <= last_if_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.err       = err_q;
endmodule
